// File: rtl/au_controller_pkg.sv
// Shared constants for the AU controller: opcodes, FSM states and the
// opcode-to-AU control table.
package au_ctrl_pkg;

    localparam int AU_W = 8;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_ADD1 = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_SUBB = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] sel;
        logic       cin;
    } au_ctl_t;

    // MUL entry is the add used by a shift-add step with Q[0]=1
    function automatic au_ctl_t op_ctl(input logic [2:0] op);
        au_ctl_t c;
        c = '{sel: 2'b00, cin: 1'b0};
        unique case (op)
            OP_PASS: c = '{sel: 2'b00, cin: 1'b0};
            OP_INC:  c = '{sel: 2'b00, cin: 1'b1};
            OP_ADD:  c = '{sel: 2'b01, cin: 1'b0};
            OP_ADD1: c = '{sel: 2'b01, cin: 1'b1};
            OP_SUB:  c = '{sel: 2'b10, cin: 1'b0};
            OP_SUBB: c = '{sel: 2'b10, cin: 1'b1};
            OP_DEC:  c = '{sel: 2'b11, cin: 1'b0};
            OP_MUL:  c = '{sel: 2'b01, cin: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/au_controller_if.sv
// Command/result handshake bundle for the AU controller.
interface au_controller_if;
    import au_ctrl_pkg::*;

    logic              start_valid;
    logic              start_ready;
    logic [2:0]        op;
    logic [AU_W-1:0]   a;
    logic [AU_W-1:0]   b;
    logic              res_valid;
    logic              res_ready;
    logic [2*AU_W-1:0] result;
    logic              carry;

    modport master (
        output start_valid, op, a, b, res_ready,
        input  start_ready, res_valid, result, carry
    );

    modport slave (
        input  start_valid, op, a, b, res_ready,
        output start_ready, res_valid, result, carry
    );

endinterface

// File: rtl/au_controller_arithmatic_unit.sv
// 8-bit arithmetic unit: sel picks y operand (0, y, ~y, all-ones);
// subtract uses inverted carry-in so cin=1 means borrow.
module arithmatic_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [1:0]       i_sel,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_f,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_opnd;
    logic             w_ci;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_opnd = '0;
        w_ci   = i_cin;
        unique case (i_sel)
            2'b00: w_opnd = '0;
            2'b01: w_opnd = i_y;
            2'b10: begin
                w_opnd = ~i_y;
                w_ci   = ~i_cin;
            end
            2'b11: w_opnd = '1;
        endcase
    end

    assign w_sum  = {1'b0, i_x} + {1'b0, w_opnd} + {{WIDTH{1'b0}}, w_ci};
    assign o_f    = w_sum[WIDTH-1:0];
    assign o_cout = w_sum[WIDTH];

endmodule

// File: rtl/au_controller.sv
// AU controller: single-cycle ops through one shared AU, and an
// 8-step shift-add multiply reusing the same AU.
module au_controller
    import au_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    au_controller_if.slave bus
);

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_m;
    logic [2:0]         r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_carry;

    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic [1:0]         w_sel;
    logic               w_cin;
    logic [WIDTH-1:0]   w_f;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_pq;
    au_ctl_t            w_ctl;

    arithmatic_unit #(.WIDTH(WIDTH)) u_au (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_sel  (w_sel),
        .i_cin  (w_cin),
        .o_f    (w_f),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_valid)
                    w_next = (bus.op == OP_MUL) ? S_MUL : S_EXEC;
            end
            S_EXEC: w_next = S_DONE;
            S_MUL: begin
                if (r_cnt == 3'd7) w_next = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready) w_next = S_IDLE;
            end
        endcase
    end

    // Latched operands live in Q/M so EXEC and MUL share the AU inputs
    always_comb begin
        w_ctl = op_ctl(r_op);
        w_x   = r_q;
        w_y   = r_m;
        w_sel = w_ctl.sel;
        w_cin = w_ctl.cin;
        if (r_state == S_MUL) begin
            w_x   = r_p;
            w_sel = r_q[0] ? 2'b01 : 2'b00;
            w_cin = 1'b0;
        end
    end

    assign w_pq = {w_cout, w_f, r_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        r_op  <= bus.op;
                        r_p   <= '0;
                        r_q   <= bus.a;
                        r_m   <= bus.b;
                        r_cnt <= '0;
                    end
                end
                S_EXEC: begin
                    r_result <= {{WIDTH{1'b0}}, w_f};
                    r_carry  <= w_cout;
                end
                S_MUL: begin
                    r_p   <= w_pq[2*WIDTH-1:WIDTH];
                    r_q   <= w_pq[WIDTH-1:0];
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_result <= w_pq;
                        r_carry  <= 1'b0;
                    end
                end
                S_DONE: ;
            endcase
        end
    end

    assign bus.start_ready = (r_state == S_IDLE);
    assign bus.res_valid   = (r_state == S_DONE);
    assign bus.result      = r_result;
    assign bus.carry       = r_carry;

endmodule

// File: tb/tb_au_controller.sv
// Scoreboard bench for au_controller: random commands against an
// arithmetic reference model, plus hold, back-to-back and reset cases.
module tb_au_controller;
    import au_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    au_controller_if bus();

    au_controller #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        c;
        int          k;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rr_rand = 1'b0;
    bit   seen = 1'b0;
    bit   have = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operation's meaning
    function automatic logic [16:0] ref_op(logic [2:0] o, logic [7:0] x, logic [7:0] y);
        int r;
        logic c;
        r = 0;
        c = 1'b0;
        case (o)
            OP_PASS: r = x;
            OP_INC:  begin r = (x + 1) % 256;     c = (x == 255); end
            OP_ADD:  begin r = (x + y) % 256;     c = (x + y) > 255; end
            OP_ADD1: begin r = (x + y + 1) % 256; c = (x + y + 1) > 255; end
            OP_SUB:  begin r = (x - y + 256) % 256;     c = (x >= y); end
            OP_SUBB: begin r = (x - y - 1 + 512) % 256; c = (x > y); end
            OP_DEC:  begin r = (x + 255) % 256;   c = (x != 0); end
            default: r = x * y;
        endcase
        return {c, r[15:0]};
    endfunction

    always @(negedge clk) begin
        if (rr_rand) bus.res_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (bus.res_valid) begin
            if (!seen) begin
                seen = 1'b1;
                have = (sb.size() > 0);
                if (have) begin
                    cur = sb.pop_front();
                    chk("latency", cyc + 1 - cur.k, cur.lat);
                end else begin
                    chk("unexpected_result", bus.res_valid, 1'b0);
                end
            end
            if (have) begin
                chk("result", bus.result, cur.res);
                chk("carry", bus.carry, cur.c);
            end
        end else begin
            seen = 1'b0;
        end
    end

    task automatic send(logic [2:0] o, logic [7:0] x, logic [7:0] y);
        int n;
        exp_t e;
        logic [16:0] m;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        bus.start_valid = 1'b1;
        n = 0;
        while (!bus.start_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.start_ready) begin
            chk("accept_timeout", bus.start_ready, 1'b1);
            bus.start_valid = 1'b0;
            return;
        end
        m = ref_op(o, x, y);
        e.res = m[15:0];
        e.c = m[16];
        e.k = cyc + 1;
        e.lat = (o == OP_MUL) ? 9 : 2;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.op = 3'($urandom);
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.res_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    function automatic logic [7:0] pick();
        int s;
        s = $urandom_range(0, 5);
        if (s == 0) return 8'h00;
        if (s == 1) return 8'hFF;
        return 8'($urandom);
    endfunction

    initial begin
        int n;
        bus.start_valid = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.res_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_result", bus.result, 16'h0000);
        chk("rst_carry", bus.carry, 1'b0);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_start_ready", bus.start_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        send(OP_ADD, 8'd36, 8'd24);
        send(OP_SUB, 8'd24, 8'd36);
        send(OP_SUB, 8'd36, 8'd24);
        send(OP_INC, 8'd255, 8'd7);
        send(OP_DEC, 8'd0, 8'd9);
        send(OP_PASS, 8'hA5, 8'h3C);
        send(OP_ADD1, 8'd200, 8'd55);
        send(OP_SUBB, 8'd0, 8'd0);
        send(OP_MUL, 8'd255, 8'd255);
        send(OP_MUL, 8'd36, 8'd24);
        drain();

        bus.res_ready = 1'b0;
        send(OP_ADD, 8'd10, 8'd20);
        n = 0;
        while (!bus.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reach_done", bus.res_valid, 1'b1);
        repeat (5) begin
            bus.start_valid = 1'b1;
            bus.op = 3'($urandom);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            chk("hold_start_ready", bus.start_ready, 1'b0);
            @(negedge clk);
        end
        bus.start_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_res_valid", bus.res_valid, 1'b0);
        chk("release_start_ready", bus.start_ready, 1'b1);
        @(negedge clk);
        drain();

        send(OP_MUL, 8'd200, 8'd100);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_result", bus.result, 16'h0000);
        chk("abort_carry", bus.carry, 1'b0);
        chk("abort_res_valid", bus.res_valid, 1'b0);
        chk("abort_start_ready", bus.start_ready, 1'b1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(OP_ADD, 8'd1, 8'd1);
        drain();

        rr_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(3'($urandom_range(0, 7)), pick(), pick());
        end
        drain();
        rr_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/au_controller.md
AU_CONTROLLER -- requirements
Module: au_controller

Interface
REQ-001 Parameter: WIDTH, 8, operand width; this block supports only the value 8.
REQ-002 clk  input  1  system clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_valid  input  1  a command is presented.
REQ-005 start_ready  output  1  the block accepts a command; high only in IDLE.
REQ-006 op  input  3  opcode, sampled at accept.
REQ-007 a  input  8  operand X, sampled at accept.
REQ-008 b  input  8  operand Y, sampled at accept.
REQ-009 res_valid  output  1  result and carry are valid; high only in DONE.
REQ-010 res_ready  input  1  the consumer takes the result.
REQ-011 result  output  16  operation result.
REQ-012 carry  output  1  carry-out of the operation.

Function
REQ-013 A command is accepted on a rising edge where start_valid and start_ready are both high; a, b and op are latched on that edge, and later input changes have no effect.
REQ-014 The AU select and carry-in mapping per opcode {sel1,sel0,cin} SHALL be:
- 0 PASS: 00,0
- 1 INC: 00,1
- 2 ADD: 01,0
- 3 ADD1: 01,1
- 4 SUB: 10,0 (x-y)
- 5 SUBB: 10,1 (x-y-1)
- 6 DEC: 11,0
- 7 MUL: multi-cycle.
REQ-015 All eight opcodes are legal; no error path exists.
REQ-016 FSM states are IDLE, EXEC, MUL and DONE; reset enters IDLE.
REQ-017 IDLE -> EXEC on accept of opcodes 0-6; IDLE -> MUL on accept of opcode 7.
REQ-018 EXEC lasts one cycle, drives the AU with the latched operands, and registers result={8'h00,f} and carry=cout; EXEC -> DONE.
REQ-019 Single-op latency: accept at edge k gives res_valid high from edge k+2.
REQ-020 MUL uses shift-add over exactly 8 MUL cycles, with P=8'h00, Q=a, M=b at accept.
REQ-021 Each MUL step: if Q[0]=1, drive AU ADD (01,0) with x=P, y=M; otherwise drive AU (00,0) with x=P. Then {P,Q} <= {cout,f,Q}>>1.
REQ-022 After step 8: result={P,Q}, carry=0, MUL -> DONE; accept at edge k gives res_valid from edge k+9.
REQ-023 The MUL step counter is 3 bits and wraps 7->0 on the final step.
REQ-024 DONE holds result, carry and res_valid stable until res_ready is high on an edge; then DONE -> IDLE and res_valid falls.
REQ-025 With res_ready held high, a new command can be accepted one cycle after the DONE handshake (via IDLE); no accept occurs in DONE.
REQ-026 start_valid outside IDLE is ignored and not queued.
REQ-027 result and carry retain their last values in IDLE until overwritten.

Reset
REQ-028 On rst high, asynchronously: state=IDLE, result=16'h0000, carry=0, res_valid=0, P/Q/M/counter=0.
REQ-029 start_ready follows state, so it reads 1 during reset.
REQ-030 rst asserted mid-EXEC or mid-MUL aborts the operation with no result delivered.

Structure
REQ-031 Package au_ctrl_pkg holds the opcode constants (OP_PASS..OP_MUL), the FSM state encoding, and the opcode-to-{sel1,sel0,cin} table.
REQ-032 Exactly one arithmatic_unit sub-module instance is used, shared by single-cycle ops and MUL steps; no other adder is used.

Verification
REQ-033 ADD a=36, b=24 -> res_valid 2 cycles after accept, result=60, carry=0.
REQ-034 SUB a=24, b=36 -> result=16'h00F4, carry=0; SUB a=36, b=24 -> result=12, carry=1.
REQ-035 INC a=255 -> result=0, carry=1; DEC a=0 -> result=16'h00FF, carry=0.
REQ-036 MUL a=255, b=255 -> result=16'hFE01 at exactly 9 cycles after accept; MUL a=36, b=24 -> 864.
REQ-037 res_ready held low 5 cycles after DONE -> result stable, start_ready=0, start_valid ignored; release -> IDLE next cycle.
REQ-038 rst pulse during MUL step 4 -> outputs 0 immediately; subsequent ADD 1+1 returns 2.
